yuv_rgb_frame_ctrl: RTL and testbench
=====================================

YUV_RGB_FRAME_CTRL -- requirements
Module: yuv_rgb_frame_ctrl

Interface
REQ-001 Parameter LAT, default 2, meaning datapath latency in vid_clk cycles that sync outputs match; legal 1..15.
REQ-002 Parameter CW, default 12, meaning width of the beat/line counters and expected-size config.
REQ-003 vid_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 cfg_en  in  1  request conversion enabled; sampled per state machine.
REQ-006 cfg_bypass  in  1  request RGB bypass of converter; shadowed at frame start.
REQ-007 cfg_exp_w  in  CW  expected active beats (4 pixels each) per line.
REQ-008 cfg_exp_h  in  CW  expected active lines per frame.
REQ-009 err_clr  in  1  clears sticky error flags.
REQ-010 TPG_HS, TPG_VS, TPG_DE  in  1 each  source timing, active-high.
REQ-011 HS, VS, DE  out  1 each  timing delayed to align with converter output.
REQ-012 act_bypass  out  1  shadowed bypass select, aligned with DE.
REQ-013 frm_done  out  1  one-cycle pulse at each completed frame.
REQ-014 meas_w, meas_h  out  CW each  last measured line width / frame height.
REQ-015 err_w, err_h  out  1 each  sticky size-mismatch flags.
REQ-016 state  out  2  current FSM state encoding.

Function
REQ-017 Edge detect: vs_rise = TPG_VS & ~prev_vs; de_fall = ~TPG_DE & prev_de; prev_* registered every cycle.
REQ-018 FSM states: IDLE=0, ARM=1, ACTIVE=2; encoding 3 unreachable, SHALL return to IDLE next cycle.
REQ-019 IDLE -> ARM when cfg_en=1; else stay.
REQ-020 ARM -> ACTIVE on vs_rise; ARM -> IDLE if cfg_en=0 (checked before vs_rise).
REQ-021 On ARM->ACTIVE, shadow regs SHALL latch cfg_bypass, cfg_exp_w, cfg_exp_h; line/beat counters cleared; no frm_done.
REQ-022 In ACTIVE on vs_rise: frm_done=1 next cycle, meas_h<=line count, err_h set if line count != exp_h shadow, shadows re-latched, line count cleared; if cfg_en=0 at that edge -> IDLE, else stay ACTIVE.
REQ-023 Config input changes mid-frame SHALL have no effect until next vs_rise.
REQ-024 Beat counter increments on each TPG_DE=1 cycle in ACTIVE, saturating at 2^CW-1.
REQ-025 On de_fall in ACTIVE: meas_w<=beat count, err_w set if beat count != exp_w shadow, line count +1 (saturating), beat count cleared.
REQ-026 de_fall and vs_rise in same cycle: line SHALL be closed first and included in that frame's height.
REQ-027 Gating: de_g = TPG_DE & (state==ACTIVE); frames starting mid-line before ACTIVE produce DE=0.
REQ-028 HS, VS, de_g, bypass shadow SHALL pass through identical LAT-stage shift registers; outputs equal inputs exactly LAT cycles earlier.
REQ-029 err_clr=1 clears err_w/err_h; a new mismatch in same cycle wins (flag stays 1).
REQ-030 Outputs other than shift chain SHALL be registered; no combinational input-to-output path.

Reset
REQ-031 rst=0 at a clock edge: state=IDLE, all counters, shadows, meas_w/meas_h=0, err_w/err_h=0, frm_done=0, all shift-register stages 0 (HS/VS/DE/act_bypass=0 for LAT cycles after release).
REQ-032 Reset mid-frame SHALL abort; after release, DE stays 0 until a full ARM->ACTIVE transition.

Verification
REQ-033 LAT=2, cfg_en=1, exp_w=480, exp_h=1080, 1080 lines x 480 beats -> second vs_rise gives frm_done pulse, meas_w=480, meas_h=1080, err_w=err_h=0; DE/HS/VS equal inputs delayed 2 cycles.
REQ-034 One line of 479 beats in frame -> err_w=1 sticky, meas_w=479 after that line; err_clr pulse -> 0; err_clr coinciding with a 479-beat line end -> stays 1.
REQ-035 cfg_bypass toggled 0->1 mid-frame -> act_bypass stays 0 until LAT cycles after next vs_rise, then 1.
REQ-036 cfg_en asserted while TPG_DE high mid-frame -> state ARM, output DE=0 until first vs_rise + LAT; cfg_en=0 -> IDLE at following vs_rise, DE forced 0.
REQ-037 rst=0 during active line -> next cycle state=0, counters 0; after release with cfg_en=1, first frame produces no frm_done, second frame measured correctly.
REQ-038 de_fall and vs_rise same cycle with 1079 prior lines -> meas_h=1080, err_h=0.

Source files
------------

// File: rtl/yuv_rgb_frame_ctrl.sv
// Frame controller for the YUV->RGB path: arms on cfg_en, measures line width and
// frame height against shadowed expectations, and delays timing to match the converter.
module yuv_rgb_frame_ctrl #(
  parameter int LAT = 2,
  parameter int CW  = 12
) (
  input  logic          vid_clk,
  input  logic          rst,
  input  logic          cfg_en,
  input  logic          cfg_bypass,
  input  logic [CW-1:0] cfg_exp_w,
  input  logic [CW-1:0] cfg_exp_h,
  input  logic          err_clr,
  input  logic          TPG_HS,
  input  logic          TPG_VS,
  input  logic          TPG_DE,
  output logic          HS,
  output logic          VS,
  output logic          DE,
  output logic          act_bypass,
  output logic          frm_done,
  output logic [CW-1:0] meas_w,
  output logic [CW-1:0] meas_h,
  output logic          err_w,
  output logic          err_h,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t        state_q;
  logic          prev_vs_q, prev_de_q;
  logic [CW-1:0] beat_q, line_q;
  logic [CW-1:0] exp_w_q, exp_h_q;
  logic [CW-1:0] meas_w_q, meas_h_q;
  logic          bypass_q, frm_done_q, err_w_q, err_h_q;
  logic [3:0]    sr_q [LAT];

  logic          vs_rise, de_fall, in_active, line_close, w_mis, h_mis, de_g;
  logic [CW-1:0] beat_inc_d, line_inc_d, line_d;

  assign vs_rise    = TPG_VS & ~prev_vs_q;
  assign de_fall    = ~TPG_DE & prev_de_q;
  assign in_active  = (state_q == S_ACTIVE);
  assign line_close = in_active & de_fall;
  assign beat_inc_d = (beat_q == '1) ? beat_q : beat_q + CW'(1);
  assign line_inc_d = (line_q == '1) ? line_q : line_q + CW'(1);
  // A line closing on the same edge as vsync still belongs to the ending frame.
  assign line_d     = line_close ? line_inc_d : line_q;
  assign w_mis      = line_close & (beat_q != exp_w_q);
  assign h_mis      = in_active & vs_rise & (line_d != exp_h_q);
  assign de_g       = TPG_DE & in_active;

  always_ff @(posedge vid_clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      prev_vs_q  <= 1'b0;
      prev_de_q  <= 1'b0;
      beat_q     <= '0;
      line_q     <= '0;
      exp_w_q    <= '0;
      exp_h_q    <= '0;
      meas_w_q   <= '0;
      meas_h_q   <= '0;
      bypass_q   <= 1'b0;
      frm_done_q <= 1'b0;
      err_w_q    <= 1'b0;
      err_h_q    <= 1'b0;
    end else begin
      prev_vs_q  <= TPG_VS;
      prev_de_q  <= TPG_DE;
      frm_done_q <= 1'b0;
      err_w_q    <= (err_w_q & ~err_clr) | w_mis;
      err_h_q    <= (err_h_q & ~err_clr) | h_mis;
      case (state_q)
        S_IDLE: begin
          if (cfg_en) state_q <= S_ARM;
        end
        S_ARM: begin
          if (!cfg_en) begin
            state_q <= S_IDLE;
          end else if (vs_rise) begin
            state_q  <= S_ACTIVE;
            bypass_q <= cfg_bypass;
            exp_w_q  <= cfg_exp_w;
            exp_h_q  <= cfg_exp_h;
            beat_q   <= '0;
            line_q   <= '0;
          end
        end
        S_ACTIVE: begin
          if (de_fall) begin
            meas_w_q <= beat_q;
            beat_q   <= '0;
          end else if (TPG_DE) begin
            beat_q <= beat_inc_d;
          end
          line_q <= line_d;
          if (vs_rise) begin
            frm_done_q <= 1'b1;
            meas_h_q   <= line_d;
            bypass_q   <= cfg_bypass;
            exp_w_q    <= cfg_exp_w;
            exp_h_q    <= cfg_exp_h;
            line_q     <= '0;
            if (!cfg_en) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Timing, gated DE and bypass select share one delay line so they stay aligned.
  always_ff @(posedge vid_clk) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= {TPG_HS, TPG_VS, de_g, bypass_q};
      for (int i = 1; i < LAT; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign {HS, VS, DE, act_bypass} = sr_q[LAT-1];
  assign frm_done = frm_done_q;
  assign meas_w   = meas_w_q;
  assign meas_h   = meas_h_q;
  assign err_w    = err_w_q;
  assign err_h    = err_h_q;
  assign state    = state_q;

endmodule

// File: tb/tb_yuv_rgb_frame_ctrl.sv
// Bench for yuv_rgb_frame_ctrl: line/frame-level reference model feeding a scoreboard
// for frame reports and a delayed-timing stream, plus directed status checks.
module tb_yuv_rgb_frame_ctrl;
  localparam int LAT  = 2;
  localparam int CW   = 12;
  localparam int MAXV = 4095;

  // clock / reset
  logic vid_clk = 1'b0;
  always #5 vid_clk = ~vid_clk;

  logic          rst, cfg_en, cfg_bypass, err_clr;
  logic [CW-1:0] cfg_exp_w, cfg_exp_h;
  logic          TPG_HS, TPG_VS, TPG_DE;
  logic          HS, VS, DE, act_bypass, frm_done, err_w, err_h;
  logic [CW-1:0] meas_w, meas_h;
  logic [1:0]    state;

  yuv_rgb_frame_ctrl #(.LAT(LAT), .CW(CW)) dut (
    .vid_clk(vid_clk), .rst(rst), .cfg_en(cfg_en), .cfg_bypass(cfg_bypass),
    .cfg_exp_w(cfg_exp_w), .cfg_exp_h(cfg_exp_h), .err_clr(err_clr),
    .TPG_HS(TPG_HS), .TPG_VS(TPG_VS), .TPG_DE(TPG_DE),
    .HS(HS), .VS(VS), .DE(DE), .act_bypass(act_bypass), .frm_done(frm_done),
    .meas_w(meas_w), .meas_h(meas_h), .err_w(err_w), .err_h(err_h), .state(state)
  );

  // scoreboard
  logic [25:0] exp_q[$];
  logic [3:0]  pipe_q[$];
  int  tests = 0;
  int  fails = 0;
  bit  mon_en = 1'b0;

  // reference model: 0 idle, 1 armed, 2 active
  int mode, lines_m, meas_w_m, meas_h_m, exp_w_m, exp_h_m;
  bit byp_m, err_w_m, err_h_m;

  function automatic void model_reset();
    mode = 0; lines_m = 0; meas_w_m = 0; meas_h_m = 0;
    exp_w_m = 0; exp_h_m = 0; byp_m = 0; err_w_m = 0; err_h_m = 0;
  endfunction

  function automatic void model_latch();
    byp_m = cfg_bypass; exp_w_m = int'(cfg_exp_w); exp_h_m = int'(cfg_exp_h);
    lines_m = 0;
  endfunction

  function automatic void model_clr();
    err_w_m = 0; err_h_m = 0;
  endfunction

  function automatic void model_close_line(input int n, input bit clr);
    int m;
    if (clr) model_clr();
    if (mode == 2) begin
      m = (n > MAXV) ? MAXV : n;
      meas_w_m = m;
      if (m != exp_w_m) err_w_m = 1;
      if (lines_m < MAXV) lines_m++;
    end
  endfunction

  function automatic void model_frame_edge();
    if (mode == 2) begin
      meas_h_m = lines_m;
      if (lines_m != exp_h_m) err_h_m = 1;
      exp_q.push_back({12'(meas_w_m), 12'(meas_h_m), err_w_m, err_h_m});
      model_latch();
      mode = cfg_en ? 2 : 0;
    end else if (mode == 1) begin
      model_latch();
      mode = 2;
    end
  endfunction

  // driver tasks: every task advances exactly through tick, one call per cycle
  task automatic tick(input bit hs, input bit vs, input bit de, input bit clr);
    TPG_HS = hs; TPG_VS = vs; TPG_DE = de; err_clr = clr;
    pipe_q.push_back({hs, vs, (de && mode == 2), byp_m});
    @(posedge vid_clk); #1;
    if (!rst) foreach (pipe_q[i]) pipe_q[i] = 4'b0;
  endtask

  task automatic set_en(input bit v);
    cfg_en = v;
    if (v && mode == 0) mode = 1;
    if (!v && mode == 1) mode = 0;
  endtask

  task automatic send_line(input int n, input bit clr);
    for (int i = 0; i < n; i++) tick(0, 0, 1, 0);
    tick(1, 0, 0, clr);
    model_close_line(n, clr);
    tick(0, 0, 0, 0);
  endtask

  // n>0 makes the last line's DE fall on the same edge as the VS rise
  task automatic frame_end(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 1, 0);
    tick(0, 1, 0, 0);
    if (n > 0) model_close_line(n, 0);
    model_frame_edge();
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
  endtask

  task automatic clear_pulse();
    tick(0, 0, 0, 1);
    model_clr();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  task automatic check_status(input string name);
    check(name, {4'b0, state, meas_w, meas_h, err_w, err_h},
          {4'b0, 2'(mode), 12'(meas_w_m), 12'(meas_h_m), err_w_m, err_h_m});
  endtask

  // monitor: delayed-timing stream every cycle, frame report on each frm_done
  logic [3:0]  item;
  logic [25:0] e;
  always @(negedge vid_clk) begin
    if (pipe_q.size() > LAT) begin
      item = pipe_q.pop_front();
      if (mon_en) begin
        tests++;
        if ({HS, VS, DE, act_bypass} !== item) begin
          fails++;
          if (fails < 20)
            $display("FAIL sync t=%0t: got HS/VS/DE/byp %b expected %b", $time,
                     {HS, VS, DE, act_bypass}, item);
        end
      end
    end
    if (mon_en && frm_done !== 1'b0) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL frm_done t=%0t: got unexpected pulse, expected none", $time);
      end else begin
        e = exp_q.pop_front();
        if ({meas_w, meas_h, err_w, err_h} !== e) begin
          fails++;
          $display("FAIL frame t=%0t: got w=%0d h=%0d ew=%b eh=%b expected w=%0d h=%0d ew=%b eh=%b",
                   $time, meas_w, meas_h, err_w, err_h, e[25:14], e[13:2], e[1], e[0]);
        end
      end
    end
  end

  int w, h, nl, bw;
  bit co;

  initial begin
    rst = 0; cfg_en = 0; cfg_bypass = 0; err_clr = 0;
    cfg_exp_w = '0; cfg_exp_h = '0;
    TPG_HS = 0; TPG_VS = 0; TPG_DE = 0;
    model_reset();
    @(posedge vid_clk); #1;
    repeat (LAT) pipe_q.push_back(4'b0);
    repeat (3) tick(0, 0, 0, 0);
    rst = 1;
    mon_en = 1;
    check_status("reset_state");

    w = $urandom_range(3, 8);
    h = $urandom_range(3, 6);
    cfg_exp_w = 12'(w); cfg_exp_h = 12'(h);
    set_en(1);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    check_status("armed");
    frame_end(0);
    check_status("active_entry");

    // randomized frames with occasional short/long lines, config churn and clears
    for (int f = 0; f < 8; f++) begin
      nl = h;
      if ($urandom_range(0, 3) == 0) nl = h + 1;
      else if ($urandom_range(0, 3) == 0) nl = h - 1;
      co = 1'($urandom_range(0, 1));
      for (int l = 0; l < nl - (co ? 1 : 0); l++) begin
        bw = ($urandom_range(0, 4) == 0) ? $urandom_range(1, w + 2) : w;
        send_line(bw, ($urandom_range(0, 5) == 0));
        if ($urandom_range(0, 6) == 0) cfg_bypass = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) cfg_exp_w = 12'($urandom_range(w, w + 1));
        if ($urandom_range(0, 7) == 0) clear_pulse();
      end
      frame_end(co ? w : 0);
      check_status("frame_status");
    end

    // short line sets sticky width error; clear; clear racing a new mismatch
    cfg_exp_w = 12'(w); cfg_exp_h = 12'(h); cfg_bypass = 0;
    frame_end(0);
    clear_pulse();
    check_status("err_cleared_start");
    send_line(w, 0);
    send_line(w - 1, 0);
    check_status("short_line");
    send_line(w, 0);
    check_status("err_w_sticky");
    clear_pulse();
    check_status("err_clr_pulse");
    send_line(w - 1, 1);
    check_status("clr_vs_mismatch");

    // bypass change mid-frame only lands after the next vsync
    send_line(w, 0);
    cfg_bypass = 1;
    send_line(w, 0);
    check("byp_hold", {31'b0, act_bypass}, {31'b0, byp_m});
    frame_end(0);
    check("byp_after_vs", {31'b0, act_bypass}, {31'b0, byp_m});

    // beat counter saturation
    send_line(4100, 0);
    check_status("beat_sat");
    frame_end(0);

    // 1080-line frame whose last line closes on the vsync edge
    cfg_exp_w = 12'd2; cfg_exp_h = 12'd1080;
    frame_end(0);
    clear_pulse();
    for (int l = 0; l < 1079; l++) send_line(2, 0);
    frame_end(2);
    check_status("tall_coincide");

    // disable while active -> idle at next vsync, DE forced low
    cfg_exp_w = 12'(w); cfg_exp_h = 12'(h);
    send_line(w, 0);
    set_en(0);
    send_line(w, 0);
    frame_end(0);
    check_status("disable_idle");
    send_line(w, 0);
    // enable in the middle of a line -> armed, DE low until vsync
    repeat (3) tick(0, 0, 1, 0);
    set_en(1);
    repeat (3) tick(0, 0, 1, 0);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    check_status("arm_midline");
    frame_end(0);
    send_line(w, 0);

    // reset during an active line
    repeat (2) tick(0, 0, 1, 0);
    rst = 0;
    tick(0, 0, 1, 0);
    rst = 1;
    model_reset();
    check_status("reset_midline");
    set_en(1);
    repeat (2) tick(0, 0, 1, 0);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    check_status("post_reset_arm");
    frame_end(0);
    for (int l = 0; l < h; l++) send_line(w, 0);
    frame_end(0);
    check_status("post_reset_frame");

    repeat (LAT + 2) tick(0, 0, 0, 0);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL frames_missing: got %0d reports outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
